// File: rtl/nbj_pkg.sv
// Shared types and defaults for the not-branch-jump redirect queue.
// Purely declarative: no latency and no flow control of its own.
package nbj_pkg;

    localparam int NBJ_PC_W  = 32;
    localparam int NBJ_CUT_W = 8;
    localparam int NBJ_DEPTH = 4;

    typedef struct packed {
        logic [NBJ_PC_W-1:0]  pc;
        logic [NBJ_CUT_W-1:0] cut;
    } nbj_redirect_t;

    function automatic logic nbj_pc_aligned(input logic [1:0] pc_lo);
        return pc_lo == 2'b00;
    endfunction

endpackage

// File: rtl/nbj_phase_sync.sv
// 2-phase request synchroniser with a local ack phase: pending two edges after a req toggle.
// Backpressure: the caller simply withholds ack_i; pending stays high until it is given.
module nbj_phase_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ack_i,
    output logic pending_o,
    output logic phase_o
);

    logic s1_q;
    logic drv_s_q;
    logic ack_phase_q;
    logic ack_phase_d;

    assign ack_phase_d = ack_i ? ~ack_phase_q : ack_phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            drv_s_q     <= 1'b0;
            ack_phase_q <= 1'b0;
        end else begin
            s1_q        <= req_i;
            drv_s_q     <= s1_q;
            ack_phase_q <= ack_phase_d;
        end
    end

    assign pending_o = drv_s_q != ack_phase_q;
    assign phase_o   = ack_phase_q;

endmodule

// File: rtl/nbj_redirect_queue.sv
// Click-to-clock redirect FIFO (FWFT); push 3 edges after i_drive toggles, ack withheld while full.
// Optional NBJ_PC_ALIGN_CHECK_EN: misaligned PCs are acked but dropped, setting sticky o_misalign.
module nbj_redirect_queue
    import nbj_pkg::*;
#(
    parameter int DEPTH = NBJ_DEPTH,
    parameter int PC_W  = NBJ_PC_W,
    parameter int CUT_W = NBJ_CUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_drive,
    input  logic [PC_W-1:0]            i_nextPc_32,
    input  logic [CUT_W-1:0]           i_cutPosition_8,
    output logic                       o_free,
    output logic                       o_valid,
    output logic [PC_W-1:0]            o_pc_32,
    output logic [CUT_W-1:0]           o_cut_8,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count
`ifdef NBJ_PC_ALIGN_CHECK_EN
    ,
    output logic                       o_misalign
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [CUT_W-1:0] cut_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [CUT_W-1:0] last_cut_q, last_cut_d;

    logic pending;
    logic full;
    logic ack;
    logic push;
    logic pop;

    nbj_phase_sync u_sync (
        .clk       (clk),
        .rst_n     (rst),
        .req_i     (i_drive),
        .ack_i     (ack),
        .pending_o (pending),
        .phase_o   (o_free)
    );

    // Fullness uses the registered count, so a pop on a full cycle cannot admit a push.
    assign full = count_q == CNT_W'(DEPTH);
    assign ack  = pending && !full;
    assign pop  = o_valid && i_ready;

`ifdef NBJ_PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign push       = ack && nbj_pc_aligned(i_nextPc_32[1:0]);
    assign misalign_d = misalign_q | (ack && !push);
    assign o_misalign = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign push = ack;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_pc_d  = last_pc_q;
        last_cut_d = last_cut_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            last_pc_d  = pc_mem_q[rd_ptr_q];
            last_cut_d = cut_mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_pc_q  <= '0;
            last_cut_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_pc_q  <= last_pc_d;
            last_cut_q <= last_cut_d;
        end
    end

    // Storage is only read while occupied, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= i_nextPc_32;
            cut_mem_q[wr_ptr_q] <= i_cutPosition_8;
        end
    end

    // When empty the head fields keep showing the most recently popped entry.
    assign o_valid = count_q != '0;
    assign o_pc_32 = o_valid ? pc_mem_q[rd_ptr_q]  : last_pc_q;
    assign o_cut_8 = o_valid ? cut_mem_q[rd_ptr_q] : last_cut_q;
    assign o_count = count_q;

endmodule

// File: doc/nbj_redirect_queue.md
# nbj_redirect_queue

Clocked consumer stage directly downstream of the not-branch-jump processing stage. Accepts its asynchronous 2-phase drive/free token carrying {next PC, cut position}. Synchronises the token into the fetch clock domain and buffers it in a small FIFO. Presents redirects to the synchronous fetch unit over a valid/ready interface.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- PC_W, 32, next-PC width
- CUT_W, 8, cut-position width

Ports:
- clk  in  1  fetch-domain clock
- rst  in  1  reset; asynchronous, active-low
- i_drive  in  1  2-phase request from upstream; each toggle = one new token
- i_nextPc_32  in  PC_W  next PC; bundled data, stable from i_drive toggle until o_free toggle
- i_cutPosition_8  in  CUT_W  cut position; bundled with i_nextPc_32
- o_free  out  1  2-phase acknowledge; toggles once per consumed token
- o_valid  out  1  head entry valid
- o_pc_32  out  PC_W  head entry PC
- o_cut_8  out  CUT_W  head entry cut position
- i_ready  in  1  fetch unit accepts head this cycle
- o_count  out  $clog2(DEPTH)+1  occupancy
- o_misalign  out  1  sticky misaligned-PC flag (only with NBJ_PC_ALIGN_CHECK_EN)

## Operation
- Reset (rst low, async): sync flops = 0, ack_phase = 0, o_free = 0, FIFO empty, o_valid = 0, o_pc_32 = 0, o_cut_8 = 0, o_count = 0, o_misalign = 0.
- i_drive passes through a 2-flop synchroniser to drv_s.
- pending = (drv_s != ack_phase). o_free is ack_phase, driven directly from a flop.
- Push when pending and count < DEPTH:
  - write {i_nextPc_32, i_cutPosition_8} at wr_ptr;
  - wr_ptr += 1, wrapping modulo DEPTH;
  - toggle ack_phase.
- Full: the token stays pending and o_free does not toggle. Upstream stalls, so no token is lost. Push occurs on the first cycle count < DEPTH.
- Fullness is evaluated on the registered count before this cycle's pop. A pop while full does not allow a push in the same cycle.
- Pop when o_valid && i_ready: rd_ptr += 1, wrapping.
- Push and pop in the same cycle leave count unchanged.
- Output is first-word-fall-through: o_valid = (count != 0). o_pc_32/o_cut_8 show the entry at rd_ptr; when empty they hold the last value (0 after reset).
- Only one token can be outstanding, because upstream waits for o_free. This allows at most one push per cycle.

## Timing
- A toggle of i_drive is captured at edge N into sync stage 1 and at N+1 into drv_s.
- Push occurs at edge N+2 if not full. o_free toggles and o_count increments after N+2. o_valid rises after N+2 if the FIFO was empty.
- Minimum token-to-token spacing at the input equals the 3-cycle sync+ack round trip plus the upstream delay.
- Pop is visible on o_count and the head fields after the accepting edge.
- Reset asserted mid-operation clears the FIFO immediately and returns o_free to 0. Upstream must be reset with the same rst so its phase also returns to 0.

## Configuration
- NBJ_PC_ALIGN_CHECK_EN defined:
  - a pending token with i_nextPc_32[1:0] != 0 is acknowledged (ack_phase toggles, push timing unchanged) but not written;
  - o_misalign sets and stays 1 until reset;
  - a full FIFO still blocks the acknowledge.
- NBJ_PC_ALIGN_CHECK_EN undefined: every token is written, and the o_misalign port is absent.

## Structure
- Package nbj_pkg:
  - redirect entry struct {pc, cut};
  - PC_W/CUT_W defaults;
  - default DEPTH.
- Sub-module nbj_phase_sync:
  - 2-flop synchroniser, ack_phase flop, pending output, ack input;
  - reusable for other click-to-clock crossings.
- Top holds the FIFO storage, pointers, count and optional align check.

## Test plan
- Single token: toggle i_drive with pc=0x0000_1000, cut=0x03 -> o_free toggles and o_valid=1 with o_pc_32=0x1000, o_cut_8=0x03, exactly 3 edges after the toggle.
- Fill: i_ready=0, send 5 tokens (pc 0x10,0x14,0x18,0x1C,0x20) -> o_count=4, fifth o_free toggle withheld. Assert i_ready for one cycle -> head pops, fifth token pushed, pop order 0x10..0x20.
- Wrap: stream 10 tokens with i_ready=1 -> outputs in order, pointers wrap, o_count never exceeds 2.
- Simultaneous push/pop at count=2 -> count stays 2, data order preserved.
- Reset mid-stream with 3 entries queued -> o_valid=0, o_count=0, o_free=0 immediately. A new token after reset is accepted normally.
- With NBJ_PC_ALIGN_CHECK_EN: token pc=0x1002 -> o_free toggles, o_count stays 0, o_misalign=1. A following pc=0x1004 is queued and o_misalign remains 1.
